// File: rtl/game_stage_sequencer_if.sv
// Signal bundle between the game-flow sequencer and its surroundings: keypad, one-second tick and level controller.
// The master modport is the sequencer itself; the slave modport is the side that drives the keypad, tick and outcome inputs.
interface game_stage_sequencer_if;
    logic       startKey;
    logic       oneSecPulse;
    logic       stageEnded;
    logic       stageFailed;
    logic       lastLevelEnded;
    logic       levelEnable;
    logic       cycleLevel;
    logic [3:0] levelIndex;
    logic [2:0] screenSel;
    logic       gameOver;
    logic       gameWon;

    modport master (
        input  startKey, oneSecPulse, stageEnded, stageFailed, lastLevelEnded,
        output levelEnable, cycleLevel, levelIndex, screenSel, gameOver, gameWon
    );

    modport slave (
        output startKey, oneSecPulse, stageEnded, stageFailed, lastLevelEnded,
        input  levelEnable, cycleLevel, levelIndex, screenSel, gameOver, gameWon
    );
endinterface

// File: rtl/game_stage_sequencer.sv
// Game-flow FSM: title -> intro -> play -> result/game over/win, driving the per-level controller.
// Optional macro STAGE_WATCHDOG_EN adds a play-time limit of WATCHDOG_SEC seconds that forces GAME_OVER.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_TITLE     | waiting for start key, level index cleared on exit
// ST_INTRO     | level intro screen, held INTRO_HOLD_SEC seconds
// ST_PLAY      | level running, levelEnable high
// ST_RESULT    | stage cleared, held RESULT_HOLD_SEC seconds or key
// ST_GAME_OVER | stage failed, key returns to title
// ST_WIN       | last level cleared, key returns to title
module game_stage_sequencer #(
    parameter int NUM_LEVELS      = 4,
    parameter int INTRO_HOLD_SEC  = 2,
    parameter int RESULT_HOLD_SEC = 3,
    parameter int WATCHDOG_SEC    = 120
) (
    input  logic                  clk,
    input  logic                  resetN,
    game_stage_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        ST_TITLE     = 3'd0,
        ST_INTRO     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_RESULT    = 3'd3,
        ST_GAME_OVER = 3'd4,
        ST_WIN       = 3'd5
    } state_t;

    localparam int HOLD_MAX = (INTRO_HOLD_SEC > RESULT_HOLD_SEC) ? INTRO_HOLD_SEC : RESULT_HOLD_SEC;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [HOLD_W-1:0] INTRO_LAST  = HOLD_W'(INTRO_HOLD_SEC - 1);
    localparam logic [HOLD_W-1:0] RESULT_LAST = HOLD_W'(RESULT_HOLD_SEC - 1);
    localparam logic [3:0]        LAST_INDEX  = 4'(NUM_LEVELS - 1);

    if (NUM_LEVELS < 1 || NUM_LEVELS > 15) begin : g_bad_levels
        $error("game_stage_sequencer: NUM_LEVELS must be 1..15");
    end
    if (INTRO_HOLD_SEC < 1 || RESULT_HOLD_SEC < 1 || WATCHDOG_SEC < 1) begin : g_bad_hold
        $error("game_stage_sequencer: hold and watchdog times must be at least 1 second");
    end

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        index_q, index_d;
    logic              cycle_q, cycle_d;
    logic              level_en_q;
    logic [2:0]        screen_q;
    logic              game_over_q;
    logic              game_won_q;
    logic              key_meta_q, key_sync_q, key_prev_q;
    logic              key_edge;

`ifdef STAGE_WATCHDOG_EN
    localparam int WD_W = (WATCHDOG_SEC > 1) ? $clog2(WATCHDOG_SEC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_SEC - 1);

    logic [WD_W-1:0] play_sec_q, play_sec_d;
`endif

    // startKey is asynchronous: two flops to resolve metastability, a third for the edge detect.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            key_meta_q <= 1'b0;
            key_sync_q <= 1'b0;
            key_prev_q <= 1'b0;
        end else begin
            key_meta_q <= bus.startKey;
            key_sync_q <= key_meta_q;
            key_prev_q <= key_sync_q;
        end
    end

    assign key_edge = key_sync_q & ~key_prev_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        index_d = index_q;
        cycle_d = 1'b0;
`ifdef STAGE_WATCHDOG_EN
        play_sec_d = play_sec_q;
`endif
        case (state_q)
            ST_TITLE: begin
                if (key_edge) begin
                    index_d = '0;
                    hold_d  = '0;
                    state_d = ST_INTRO;
                end
            end
            ST_INTRO: begin
                if (bus.oneSecPulse) begin
                    if (hold_q == INTRO_LAST) begin
                        state_d = ST_PLAY;
`ifdef STAGE_WATCHDOG_EN
                        play_sec_d = '0;
`endif
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                // The level controller's outcome always beats a coincident tick or watchdog expiry.
                if (bus.stageEnded) begin
                    if (bus.stageFailed) begin
                        state_d = ST_GAME_OVER;
                    end else if (bus.lastLevelEnded || index_q == LAST_INDEX) begin
                        state_d = ST_WIN;
                    end else begin
                        hold_d  = '0;
                        state_d = ST_RESULT;
                    end
                end
`ifdef STAGE_WATCHDOG_EN
                else if (bus.oneSecPulse) begin
                    if (play_sec_q == WD_LAST) begin
                        state_d = ST_GAME_OVER;
                    end else begin
                        play_sec_d = play_sec_q + 1'b1;
                    end
                end
`endif
            end
            ST_RESULT: begin
                if (key_edge || (bus.oneSecPulse && hold_q == RESULT_LAST)) begin
                    cycle_d = 1'b1;
                    hold_d  = '0;
                    state_d = ST_INTRO;
                    if (index_q != LAST_INDEX) begin
                        index_d = index_q + 4'd1;
                    end
                end else if (bus.oneSecPulse) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_GAME_OVER, ST_WIN: begin
                if (key_edge) begin
                    index_d = '0;
                    state_d = ST_TITLE;
                end
            end
            default: begin
                state_d = ST_TITLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ST_TITLE;
            hold_q      <= '0;
            index_q     <= '0;
            cycle_q     <= 1'b0;
            level_en_q  <= 1'b0;
            screen_q    <= 3'd0;
            game_over_q <= 1'b0;
            game_won_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            index_q     <= index_d;
            cycle_q     <= cycle_d;
            level_en_q  <= (state_d == ST_PLAY);
            screen_q    <= state_d;
            game_over_q <= (state_d == ST_GAME_OVER);
            game_won_q  <= (state_d == ST_WIN);
        end
    end

`ifdef STAGE_WATCHDOG_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            play_sec_q <= '0;
        end else begin
            play_sec_q <= play_sec_d;
        end
    end
`endif

    assign bus.levelEnable = level_en_q;
    assign bus.cycleLevel  = cycle_q;
    assign bus.levelIndex  = index_q;
    assign bus.screenSel   = screen_q;
    assign bus.gameOver    = game_over_q;
    assign bus.gameWon     = game_won_q;

endmodule

// File: tb/tb_game_stage_sequencer.sv
// Directed walk through the game flow followed by random stimulus, all checked against a screen-level model.
module tb_game_stage_sequencer;
    localparam int NL = 4;
    localparam int IH = 2;
    localparam int RH = 3;
    localparam int WD = 5;

    localparam int S_TITLE = 0;
    localparam int S_INTRO = 1;
    localparam int S_PLAY  = 2;
    localparam int S_RES   = 3;
    localparam int S_OVER  = 4;
    localparam int S_WIN   = 5;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    game_stage_sequencer_if bus ();

    game_stage_sequencer #(
        .NUM_LEVELS     (NL),
        .INTRO_HOLD_SEC (IH),
        .RESULT_HOLD_SEC(RH),
        .WATCHDOG_SEC   (WD)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc_seen = 0;

    // Model: which screen is shown, the level number, seconds spent on the screen, and the raw key history.
    int m_scr, m_idx, m_cyc, m_secs, m_play;
    int kh1, kh2, kh3;

    task automatic model_reset();
        m_scr = S_TITLE; m_idx = 0; m_cyc = 0; m_secs = 0; m_play = 0;
        kh1 = 0; kh2 = 0; kh3 = 0;
    endtask

    task automatic model_step(input int key, input int sec, input int se, input int sf, input int ll);
        int press;
        // A press is seen two edges after the raw rise was first sampled.
        press = (kh2 == 1 && kh3 == 0) ? 1 : 0;
        kh3 = kh2; kh2 = kh1; kh1 = key;
        m_cyc = 0;
        if (m_scr == S_TITLE) begin
            if (press == 1) begin m_idx = 0; m_scr = S_INTRO; m_secs = 0; end
        end else if (m_scr == S_INTRO) begin
            if (sec == 1) m_secs++;
            if (m_secs == IH) begin m_scr = S_PLAY; m_play = 0; end
        end else if (m_scr == S_PLAY) begin
            if (se == 1) begin
                if (sf == 1) m_scr = S_OVER;
                else if (ll == 1 || m_idx == NL - 1) m_scr = S_WIN;
                else begin m_scr = S_RES; m_secs = 0; end
            end else begin
`ifdef STAGE_WATCHDOG_EN
                if (sec == 1) m_play++;
                if (m_play == WD) m_scr = S_OVER;
`endif
            end
        end else if (m_scr == S_RES) begin
            if (sec == 1) m_secs++;
            if (press == 1 || m_secs == RH) begin
                m_cyc = 1; m_idx++; m_scr = S_INTRO; m_secs = 0;
            end
        end else begin
            if (press == 1) begin m_idx = 0; m_scr = S_TITLE; end
        end
    endtask

    function automatic logic [10:0] observed();
        return {bus.screenSel, bus.levelEnable, bus.cycleLevel, bus.levelIndex, bus.gameOver, bus.gameWon};
    endfunction

    task automatic check_model(input string tag);
        logic [10:0] obs, exp;
        obs = observed();
        exp = {3'(m_scr), (m_scr == S_PLAY), 1'(m_cyc), 4'(m_idx), (m_scr == S_OVER), (m_scr == S_WIN)};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int key, input int sec, input int se, input int sf, input int ll, input string tag);
        bus.startKey       = 1'(key);
        bus.oneSecPulse    = 1'(sec);
        bus.stageEnded     = 1'(se);
        bus.stageFailed    = 1'(sf);
        bus.lastLevelEnded = 1'(ll);
        @(posedge clk);
        model_step(key, sec, se, sf, ll);
        #1;
        if (bus.cycleLevel === 1'b1) cyc_seen++;
        check_model(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, "idle");
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) tick(0, 1, 0, 0, 0, "sec");
    endtask

    task automatic press_key();
        tick(1, 0, 0, 0, 0, "key_n");
        tick(0, 0, 0, 0, 0, "key_n1");
        tick(0, 0, 0, 0, 0, "key_n2");
    endtask

    initial begin
        bus.startKey = 1'b0; bus.oneSecPulse = 1'b0; bus.stageEnded = 1'b0;
        bus.stageFailed = 1'b0; bus.lastLevelEnded = 1'b0;
        resetN = 1'b0;
        model_reset();
        #2;
        check_val("reset_outputs", int'(observed()), 0);
        #10 resetN = 1'b1;
        @(posedge clk); #1;
        check_model("after_reset");

        // Start key: rise sampled at edge N, INTRO at edge N+2
        tick(1, 0, 0, 0, 0, "start_n");
        check_val("start_n_screen", int'(bus.screenSel), 0);
        tick(0, 0, 0, 0, 0, "start_n1");
        check_val("start_n1_screen", int'(bus.screenSel), 0);
        tick(0, 0, 0, 0, 0, "start_n2");
        check_val("start_n2_screen", int'(bus.screenSel), 1);
        secs(1);
        check_val("intro_one_sec", int'(bus.screenSel), 1);
        secs(1);
        check_val("play_screen", int'(bus.screenSel), 2);
        check_val("play_enable", int'(bus.levelEnable), 1);
        check_val("play_index0", int'(bus.levelIndex), 0);

        // Level 0 cleared, result screen runs out
        tick(0, 0, 1, 0, 0, "clear0");
        check_val("result_screen", int'(bus.screenSel), 3);
        check_val("result_enable", int'(bus.levelEnable), 0);
        secs(2);
        tick(0, 1, 0, 0, 0, "result_expire");
        check_val("advance_pulse", int'(bus.cycleLevel), 1);
        check_val("advance_index", int'(bus.levelIndex), 1);
        check_val("advance_screen", int'(bus.screenSel), 1);
        idle(1);
        check_val("advance_pulse_one_clk", int'(bus.cycleLevel), 0);

        // Failure beats last-level flag
        secs(2);
        tick(0, 0, 1, 1, 1, "fail1");
        check_val("gameover_screen", int'(bus.screenSel), 4);
        check_val("gameover_flag", int'(bus.gameOver), 1);
        press_key();
        check_val("gameover_to_title", int'(bus.screenSel), 0);
        check_val("gameover_index", int'(bus.levelIndex), 0);

        // Key skips the result hold after one second
        press_key();
        secs(2);
        tick(0, 0, 1, 0, 0, "clear0b");
        secs(1);
        cyc_seen = 0;
        press_key();
        check_val("key_skip_screen", int'(bus.screenSel), 1);
        check_val("key_skip_index", int'(bus.levelIndex), 1);
        check_val("key_skip_pulses", cyc_seen, 1);

        // Key edge coincident with the last hold second
        secs(2);
        tick(0, 0, 1, 0, 0, "clear1");
        secs(2);
        cyc_seen = 0;
        tick(1, 0, 0, 0, 0, "coinc_n");
        tick(0, 0, 0, 0, 0, "coinc_n1");
        tick(0, 1, 0, 0, 0, "coinc_n2");
        idle(3);
        check_val("coinc_pulses", cyc_seen, 1);
        check_val("coinc_index", int'(bus.levelIndex), 2);

        // Last level reaches WIN on index alone
        secs(2);
        tick(0, 0, 1, 0, 0, "clear2");
        secs(3);
        secs(2);
        check_val("last_play_index", int'(bus.levelIndex), 3);
        cyc_seen = 0;
        tick(0, 0, 1, 0, 0, "clear3");
        check_val("win_screen", int'(bus.screenSel), 5);
        check_val("win_flag", int'(bus.gameWon), 1);
        tick(0, 1, 1, 1, 0, "ended_in_win");
        idle(2);
        check_val("win_no_pulse", cyc_seen, 0);
        check_val("win_ignores_ended", int'(bus.screenSel), 5);
        press_key();

        // Watchdog
        press_key();
        secs(2);
        secs(WD);
`ifdef STAGE_WATCHDOG_EN
        check_val("watchdog_gameover", int'(bus.screenSel), 4);
        press_key();
        press_key();
        secs(2);
`else
        check_val("no_watchdog_stays_play", int'(bus.screenSel), 2);
`endif

        // Async reset mid-play
        resetN = 1'b0;
        #1;
        check_val("async_reset_outputs", int'(observed()), 0);
        model_reset();
        #2 resetN = 1'b1;
        press_key();
        secs(2);
        tick(0, 1, 1, 0, 0, "ended_with_sec");
        check_val("outcome_beats_sec", int'(bus.screenSel), 3);
        secs(3);

        // Random play against the model
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 5) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 9) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
